// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-3 slave that exposes NREG read/write byte registers
// and NSTAT read-only status bytes, with per-address auto-increment disable.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   spi_cs          chip select (active-low), pre-synchronised to clk
//   spi_sck         SPI clock (mode 3), pre-synchronised to clk
//   spi_mosi        serial data in, pre-synchronised to clk
//   spi_miso        serial data out, MSB first, idles high
//   reg_q           register contents, byte a at [8a+7:8a]
//   reg_wstb        one-cycle pulse on the register just written
//   stat_in         status bytes, byte s read at address NREG+s
//   rd_stb          one-cycle pulse when a location is latched for shift-out
//   spi_active      high while a transaction is accepted
module spi_regfile #(
    parameter int           NREG       = 64,
    parameter int           NSTAT      = 4,
    parameter logic [127:0] NOINC_MASK = 128'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_cs,
    input  logic                    spi_sck,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic [8*NREG-1:0]       reg_q,
    output logic [NREG-1:0]         reg_wstb,
    input  logic [8*NSTAT-1:0]      stat_in,
    output logic [NREG+NSTAT-1:0]   rd_stb,
    output logic                    spi_active
);

    localparam int NLOC = NREG + NSTAT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA_W,
        S_DATA_R
    } state_t;

    state_t          state_q, state_d;
    logic            arm_q, arm_d;
    logic            sck_prev_q, sck_prev_d;
    logic            fall_q, fall_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [6:0]      rx_q, rx_d;
    logic [6:0]      addr_q, addr_d;
    logic            wr_pend_q, wr_pend_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            rd_pend_q, rd_pend_d;
    logic            inc_pend_q, inc_pend_d;
    logic [7:0]      tx_q, tx_d;
    logic            miso_q, miso_d;
    logic [7:0]      regs_q [NREG];
    logic [7:0]      regs_d [NREG];
    logic [NREG-1:0] wstb_q, wstb_d;
    logic [NLOC-1:0] rstb_q, rstb_d;

    logic            sck_rise;
    logic            sck_fall;
    logic [7:0]      rx_byte;
    logic [6:0]      lat_addr;
    logic [7:0]      lat_byte;

    function automatic logic [6:0] next_addr(input logic [6:0] a);
        return NOINC_MASK[a] ? a : a + 7'd1;
    endfunction

    assign sck_rise = !sck_prev_q && spi_sck;
    assign sck_fall = sck_prev_q && !spi_sck;
    assign rx_byte  = {rx_q, spi_mosi};

    always_comb begin
        state_d    = state_q;
        arm_d      = arm_q | spi_cs;
        sck_prev_d = spi_sck;
        fall_d     = sck_fall;
        bitcnt_d   = bitcnt_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        wr_pend_d  = 1'b0;
        wr_data_d  = wr_data_q;
        rd_pend_d  = 1'b0;
        inc_pend_d = 1'b0;
        tx_d       = tx_q;
        miso_d     = miso_q;
        regs_d     = regs_q;
        wstb_d     = '0;
        rstb_d     = '0;
        lat_addr   = inc_pend_q ? next_addr(addr_q) : addr_q;
        lat_byte   = 8'h00;

        // MISO moves one clk after the fall is detected.
        if (fall_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b1};
        end

        // Write commit, one clk after the last bit of a data byte.
        if (wr_pend_q) begin
            for (int i = 0; i < NREG; i++) begin
                if (int'(addr_q) == i) begin
                    regs_d[i] = wr_data_q;
                    wstb_d[i] = 1'b1;
                end
            end
            addr_d = next_addr(addr_q);
        end

        // Read latch; data-byte reads advance the address first.
        if (rd_pend_q) begin
            for (int i = 0; i < NREG; i++) begin
                if (int'(lat_addr) == i) lat_byte = regs_q[i];
            end
            for (int s = 0; s < NSTAT; s++) begin
                if (int'(lat_addr) == NREG + s) lat_byte = stat_in[8*s +: 8];
            end
            for (int i = 0; i < NLOC; i++) begin
                if (int'(lat_addr) == i) rstb_d[i] = 1'b1;
            end
            addr_d = lat_addr;
            tx_d   = lat_byte;
        end

        unique case (state_q)
            S_IDLE: begin
                bitcnt_d = 3'd0;
                // arm_q blocks a transaction already in flight at reset.
                if (!spi_cs && arm_q) state_d = S_CMD;
            end
            S_CMD, S_DATA_W, S_DATA_R: begin
                if (spi_cs) begin
                    state_d  = S_IDLE;
                    bitcnt_d = 3'd0;
                end else if (sck_rise) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    rx_d     = rx_byte[6:0];
                    if (bitcnt_q == 3'd7) begin
                        if (state_q == S_CMD) begin
                            addr_d    = rx_byte[6:0];
                            state_d   = rx_byte[7] ? S_DATA_R : S_DATA_W;
                            rd_pend_d = rx_byte[7];
                        end else if (state_q == S_DATA_W) begin
                            wr_pend_d = 1'b1;
                            wr_data_d = rx_byte;
                        end else begin
                            rd_pend_d  = 1'b1;
                            inc_pend_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        if (spi_cs) begin
            tx_d   = 8'hFF;
            miso_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            arm_q      <= 1'b0;
            sck_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            bitcnt_q   <= 3'd0;
            rx_q       <= 7'd0;
            addr_q     <= 7'd0;
            wr_pend_q  <= 1'b0;
            wr_data_q  <= 8'd0;
            rd_pend_q  <= 1'b0;
            inc_pend_q <= 1'b0;
            tx_q       <= 8'hFF;
            miso_q     <= 1'b1;
            for (int i = 0; i < NREG; i++) regs_q[i] <= 8'd0;
            wstb_q     <= '0;
            rstb_q     <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            sck_prev_q <= sck_prev_d;
            fall_q     <= fall_d;
            bitcnt_q   <= bitcnt_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            wr_pend_q  <= wr_pend_d;
            wr_data_q  <= wr_data_d;
            rd_pend_q  <= rd_pend_d;
            inc_pend_q <= inc_pend_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            regs_q     <= regs_d;
            wstb_q     <= wstb_d;
            rstb_q     <= rstb_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regq
        assign reg_q[8*g +: 8] = regs_q[g];
    end

    assign spi_miso   = miso_q;
    assign reg_wstb   = wstb_q;
    assign rd_stb     = rstb_q;
    assign spi_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed bench for spi_regfile with NREG=64, NSTAT=4
// and auto-increment disabled at address 11.
module tb_spi_regfile;

    localparam int NREG  = 64;
    localparam int NSTAT = 4;
    localparam int NLOC  = NREG + NSTAT;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  spi_cs;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [8*NREG-1:0]     reg_q;
    logic [NREG-1:0]       reg_wstb;
    logic [8*NSTAT-1:0]    stat_in;
    logic [NLOC-1:0]       rd_stb;
    logic                  spi_active;

    int checks = 0;
    int errors = 0;
    int wcnt [NREG];
    int rcnt [NLOC];
    logic [8*NREG-1:0] mdl;
    logic [7:0] r0, r1, r2;
    int snap_a, snap_b;

    spi_regfile #(
        .NREG      (NREG),
        .NSTAT     (NSTAT),
        .NOINC_MASK(128'h800)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs    (spi_cs),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .reg_q     (reg_q),
        .reg_wstb  (reg_wstb),
        .stat_in   (stat_in),
        .rd_stb    (rd_stb),
        .spi_active(spi_active)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NREG; i++) wcnt[i] = 0;
        for (int i = 0; i < NLOC; i++) rcnt[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) if (reg_wstb[i]) wcnt[i] = wcnt[i] + 1;
        for (int i = 0; i < NLOC; i++) if (rd_stb[i]) rcnt[i] = rcnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = b[i];
            clk_n(4);
            r[i]     = spi_miso;
            spi_sck  = 1'b1;
            clk_n(4);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        clk_n(3);
    endtask

    task automatic cs_high();
        clk_n(3);
        spi_cs = 1'b1;
        clk_n(4);
    endtask

    task automatic wr2(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        cs_low();
        spi_byte(a, dummy);
        spi_byte(d, dummy);
        cs_high();
    endtask

    initial begin
        rst      = 1'b1;
        spi_cs   = 1'b1;
        spi_sck  = 1'b1;
        spi_mosi = 1'b0;
        stat_in  = 32'hA4_B3_81_5A;
        mdl      = '0;
        clk_n(3);
        chk("rst_reg_q", reg_q, '0);
        chk("rst_wstb", reg_wstb, '0);
        chk("rst_rd_stb", rd_stb, '0);
        chk("rst_miso", spi_miso, 1'b1);
        chk("rst_active", spi_active, 1'b0);
        rst = 1'b0;
        clk_n(3);

        // Burst write at 5 and 6
        cs_low();
        chk("active_hi", spi_active, 1'b1);
        spi_byte(8'h05, r0);
        chk("cmd_miso_ff", r0, 8'hFF);
        spi_byte(8'hAA, r1);
        spi_byte(8'h55, r2);
        cs_high();
        chk("active_lo", spi_active, 1'b0);
        mdl[8*5 +: 8] = 8'hAA;
        mdl[8*6 +: 8] = 8'h55;
        chk("burst_regs", reg_q, mdl);
        chk("wstb5_cnt", wcnt[5], 1);
        chk("wstb6_cnt", wcnt[6], 1);

        // Streaming port at 11 does not increment
        cs_low();
        spi_byte(8'h0B, r0);
        spi_byte(8'h10, r0);
        spi_byte(8'h20, r0);
        spi_byte(8'h30, r0);
        spi_byte(8'h4E, r0);
        cs_high();
        mdl[8*11 +: 8] = 8'h4E;
        chk("noinc_regs", reg_q, mdl);
        chk("wstb11_cnt", wcnt[11], 4);
        chk("wstb12_cnt", wcnt[12], 0);

        // Read back 3 and 4
        cs_low();
        spi_byte(8'h03, r0);
        spi_byte(8'h3C, r0);
        spi_byte(8'hC3, r0);
        cs_high();
        mdl[8*3 +: 8] = 8'h3C;
        mdl[8*4 +: 8] = 8'hC3;
        chk("preload_regs", reg_q, mdl);
        cs_low();
        spi_byte(8'h83, r0);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_high();
        chk("rd_cmd_ff", r0, 8'hFF);
        chk("rd_reg3", r1, 8'h3C);
        chk("rd_reg4", r2, 8'hC3);
        chk("rstb3_cnt", rcnt[3], 1);
        chk("rstb4_cnt", rcnt[4], 1);
        chk("rd_no_write", reg_q, mdl);

        // Status byte 1
        cs_low();
        spi_byte(8'hC1, r0);
        spi_byte(8'h00, r1);
        cs_high();
        chk("rd_stat1", r1, 8'h81);
        chk("rstb65_cnt", rcnt[65], 1);

        // Unmapped 0x7F reads 0, then wraps to 0
        wr2(8'h00, 8'h77);
        mdl[7:0] = 8'h77;
        chk("reg0_preload", reg_q, mdl);
        snap_a = rcnt[0];
        cs_low();
        spi_byte(8'hFF, r0);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_high();
        chk("rd_7f_zero", r1, 8'h00);
        chk("rd_wrap_reg0", r2, 8'h77);
        chk("rstb0_wrap", rcnt[0] - snap_a, 1);

        // Abort after 5 bits of a data byte
        snap_a = wcnt[8];
        cs_low();
        spi_byte(8'h08, r0);
        spi_bits(8'hFF, 5, r0);
        cs_high();
        chk("abort_regs", reg_q, mdl);
        chk("abort_no_wstb", wcnt[8] - snap_a, 0);
        wr2(8'h08, 8'h99);
        mdl[8*8 +: 8] = 8'h99;
        chk("after_abort_regs", reg_q, mdl);
        chk("after_abort_wstb", wcnt[8] - snap_a, 1);

        // Reset during a read with cs held low
        cs_low();
        spi_byte(8'h84, r0);
        spi_bits(8'h00, 3, r0);
        rst = 1'b1;
        clk_n(2);
        rst = 1'b0;
        clk_n(1);
        chk("mid_rst_regs", reg_q, '0);
        chk("mid_rst_miso", spi_miso, 1'b1);
        chk("mid_rst_active", spi_active, 1'b0);
        chk("mid_rst_rd_stb", rd_stb, '0);
        snap_b = rcnt[4] + rcnt[5];
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        chk("post_rst_miso1", r1, 8'hFF);
        chk("post_rst_miso2", r2, 8'hFF);
        chk("post_rst_idle", spi_active, 1'b0);
        chk("post_rst_no_rd", rcnt[4] + rcnt[5] - snap_b, 0);
        cs_high();
        wr2(8'h00, 8'h11);
        mdl      = '0;
        mdl[7:0] = 8'h11;
        chk("post_rst_write", reg_q, mdl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI-slave register file, next generation of the panel-controller CSR port. It replaces the fixed CSR map with a generic array of NREG read/write byte registers plus NSTAT read-only status bytes. Every location reads back. An explicit read/write bit selects the direction, and a per-address mask disables auto-increment for streaming ports. Sits between the SPI pin synchronisers and the controller's configuration/LUT/op logic.

## Interface
- NREG, 64: number of R/W byte registers at addresses 0..NREG-1; 1..128
- NSTAT, 4: number of read-only status bytes at NREG..NREG+NSTAT-1; NREG+NSTAT ≤ 128
- NOINC_MASK, 128'h0: bit a=1 means address a does not auto-increment
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- spi_cs  in  1  chip select, active-low, already synced to clk
- spi_sck  in  1  SPI clock, mode 3, already synced
- spi_mosi  in  1  data in, already synced
- spi_miso  out  1  data out
- reg_q  out  8*NREG  register contents; byte a at [8a+7:8a]
- reg_wstb  out  NREG  one-cycle pulse on the register just written
- stat_in  in  8*NSTAT  status bytes; byte s is read at address NREG+s
- rd_stb  out  NREG+NSTAT  one-cycle pulse when a location's value is latched for shift-out
- spi_active  out  1  high while a transaction is accepted

## Operation
- SPI mode 3. MOSI is sampled on a detected SCK rise (previous sampled sck=0, current sampled sck=1). MISO changes on a detected SCK fall, MSB first.
- Byte 0 is the command. Bit 7 = R (1 = read, 0 = write). Bits 6:0 = start address A. The block then enters DATA phase.
- Write, DATA bytes:
  - Each completed byte is written to the current address.
  - The address then increments (7-bit, 7'h7F wraps to 0), unless NOINC_MASK[addr]=1.
  - Writes to addresses ≥ NREG are discarded, with no strobe, but the address still increments.
- Read:
  - At the end of the command byte, byte(A) is latched into the TX shifter.
  - At the end of each DATA byte, the address advances under the same increment rules and the new byte is latched.
  - MOSI is ignored during DATA bytes of a read.
  - Addresses ≥ NREG+NSTAT read 8'h00 with no rd_stb.
- TX shifter holds 8'hFF outside transactions, so MISO idles high and the command byte shifts out 1s.
- spi_cs high:
  - bit counter is cleared and the phase returns to COMMAND;
  - a partial byte is discarded, with no write and no increment.
- State machine: IDLE (cs high) -> CMD (cs low) -> DATA_W or DATA_R (after 8th bit) -> IDLE (cs high).
- If rst is deasserted while cs is low, the block stays in IDLE until cs has gone high. A transaction cut by reset is never resumed.
- Reset values:
  - reg_q = 0
  - reg_wstb, rd_stb = 0
  - spi_miso = 1
  - spi_active = 0
  - TX shifter = 8'hFF
  - address = 0
  - phase = IDLE

## Timing
- Let E be the clk edge that samples the SCK rise of bit 7 of a byte.
- Write commit:
  - reg_q byte updates at E+1, and reg_wstb[addr] is high for exactly the cycle after E+1.
  - The incremented address is valid from E+1.
- Read latch:
  - TX shifter loads at E+1, and rd_stb for that location is high for one cycle.
  - stat_in is sampled at E+1.
- SCK low and high half-periods must each be at least 3 clk cycles; this guarantees the latch precedes the next SCK fall.
- spi_miso updates 1 clk after the edge that detects an SCK fall.
- spi_active rises the clk after cs is sampled low (from IDLE) and falls the clk after cs is sampled high.
- rst overrides everything in the same edge. A commit pending at E+1 with rst high at E+1 is dropped.

## Test plan
- Write 0x05, 0xAA, 0x55, then cs high -> reg 5 = 0xAA and reg 6 = 0x55; reg_wstb[5] and reg_wstb[6] each pulse once; no other register changes.
- Write 0x0B with 4 data bytes, NOINC_MASK[11]=1 -> reg 11 = last byte, four reg_wstb[11] pulses, reg 12 untouched.
- Read: preload reg 3 = 0x3C and reg 4 = 0xC3, send 0x83 plus 2 dummy bytes -> MISO = 0xFF, 0x3C, 0xC3; rd_stb[3] and rd_stb[4] pulse.
- Read of a status byte (NREG=64): stat_in byte 1 = 0x81, send 0xC1 -> MISO returns 0x81. Read of address 0x7F -> 0x00, then the address wraps and reg 0 is returned next.
- Abort: cs high after 5 bits of a write data byte -> no strobe and register unchanged. A new transaction then operates normally.
- Reset mid-read with cs held low -> outputs at reset values and MISO stays 1. After cs goes high and a new write to 0x00 of 0x11, reg 0 = 0x11.
